// File: rtl/bit_unstuff_decoder.sv
// Receive-path bit unstuffer: drops the 0 stuffed after every RUN_LEN consecutive 1s,
// flags stuffing violations, marks packet end and counts removed stuff bits per packet.
module bit_unstuff_decoder #(
   parameter int RUN_LEN = 6,
   parameter int CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_sending,
   input  logic             in_bit,
   output logic             out_bit,
   output logic             out_valid,
   output logic             stuff_err,
   output logic             pkt_done,
   output logic [CNT_W-1:0] stuff_cnt,
   output logic             busy
);

   localparam int ONES_W = $clog2(RUN_LEN + 1);
   localparam logic [ONES_W-1:0] RUN_MAX = ONES_W'(RUN_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, STUFF, ERROR} state_t;

   state_t            state;
   logic [ONES_W-1:0] ones;
   logic [ONES_W-1:0] ones_inc;

   assign ones_inc = ones + ONES_W'(1);

   // Strobes default low every cycle so each one lasts exactly one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ones      <= '0;
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         stuff_err <= 1'b0;
         pkt_done  <= 1'b0;
         stuff_cnt <= '0;
         busy      <= 1'b0;
      end else begin
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         stuff_err <= 1'b0;
         pkt_done  <= 1'b0;
         if (state == IDLE) begin
            if (in_sending) begin
               // A single bit can never complete a run because RUN_LEN is at least 2.
               stuff_cnt <= '0;
               out_valid <= 1'b1;
               out_bit   <= in_bit;
               ones      <= ONES_W'(in_bit);
               state     <= RUN;
               busy      <= 1'b1;
            end
         end else if (!in_sending) begin
            pkt_done <= 1'b1;
            ones     <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
         end else begin
            case (state)
               RUN: begin
                  out_valid <= 1'b1;
                  out_bit   <= in_bit;
                  if (in_bit) begin
                     ones <= ones_inc;
                     if (ones_inc == RUN_MAX)
                        state <= STUFF;
                  end else begin
                     ones <= '0;
                  end
               end
               STUFF: begin
                  ones <= '0;
                  if (in_bit) begin
                     stuff_err <= 1'b1;
                     state     <= ERROR;
                  end else begin
                     if (stuff_cnt != CNT_MAX)
                        stuff_cnt <= stuff_cnt + CNT_W'(1);
                     state <= RUN;
                  end
               end
               default: begin
                  ones <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_unstuff_decoder.sv
// Directed bench for bit_unstuff_decoder: a RUN_LEN=6 instance driven from a vector table
// and a RUN_LEN=3/CNT_W=2 instance driven by hand-written sequences.
module tb_bit_unstuff_decoder;

   typedef struct {
      logic       s;
      logic       b;
      logic       v;
      logic       ob;
      logic       err;
      logic       done;
      logic       bsy;
      logic [7:0] cnt;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_sending_a, in_bit_a, out_bit_a, out_valid_a, stuff_err_a, pkt_done_a, busy_a;
   logic [7:0] stuff_cnt_a;
   logic       in_sending_b, in_bit_b, out_bit_b, out_valid_b, stuff_err_b, pkt_done_b, busy_b;
   logic [1:0] stuff_cnt_b;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vec_q[$];

   bit_unstuff_decoder #(.RUN_LEN(6), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .in_sending(in_sending_a), .in_bit(in_bit_a),
      .out_bit(out_bit_a), .out_valid(out_valid_a), .stuff_err(stuff_err_a),
      .pkt_done(pkt_done_a), .stuff_cnt(stuff_cnt_a), .busy(busy_a));

   bit_unstuff_decoder #(.RUN_LEN(3), .CNT_W(2)) dut_b (
      .clock(clock), .reset(reset), .in_sending(in_sending_b), .in_bit(in_bit_b),
      .out_bit(out_bit_b), .out_valid(out_valid_b), .stuff_err(stuff_err_b),
      .pkt_done(pkt_done_b), .stuff_cnt(stuff_cnt_b), .busy(busy_b));

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int idx, input logic [7:0] act,
                              input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic b, input logic v, input logic ob,
                      input logic err, input logic done, input logic bsy, input int cnt);
      vec_t r;
      r.s = s; r.b = b; r.v = v; r.ob = ob; r.err = err; r.done = done; r.bsy = bsy;
      r.cnt = 8'(cnt);
      vec_q.push_back(r);
   endtask

   task automatic add_fwd(input logic b, input int cnt);
      add(1'b1, b, 1'b1, b, 1'b0, 1'b0, 1'b1, cnt);
   endtask

   task automatic add_end(input int cnt);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
   endtask

   task automatic add_idle(input int cnt);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic b, input logic sb, input logic bb);
      in_sending_a = s; in_bit_a = b; in_sending_b = sb; in_bit_b = bb;
   endtask

   task automatic check_b(input string tag, input int idx, input logic v, input logic ob,
                          input logic err, input logic done, input int cnt);
      checkOutput({tag, ".valid"}, idx, {7'd0, out_valid_b}, {7'd0, v});
      checkOutput({tag, ".bit"},   idx, {7'd0, out_bit_b},   {7'd0, ob});
      checkOutput({tag, ".err"},   idx, {7'd0, stuff_err_b}, {7'd0, err});
      checkOutput({tag, ".done"},  idx, {7'd0, pkt_done_b},  {7'd0, done});
      checkOutput({tag, ".cnt"},   idx, {6'd0, stuff_cnt_b}, 8'(cnt));
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // 0101 pattern, no stuffing
      for (int i = 0; i < 8; i++) add_fwd(1'(i % 2), 0);
      add_end(0); add_idle(0);
      // six 1s then the stuffed 0 and one more 1
      for (int i = 0; i < 6; i++) add_fwd(1'b1, 0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      add_fwd(1'b1, 1); add_end(1); add_idle(1);
      // seven 1s: violation, rest ignored
      for (int i = 0; i < 6; i++) add_fwd(1'b1, 0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      add_end(0); add_idle(0);
      // packet ending right at the stuff position is legal
      for (int i = 0; i < 6; i++) add_fwd(1'b1, 0);
      add_end(0); add_idle(0);
      // back-to-back packets with a single low cycle between them
      add_fwd(1'b1, 0); add_fwd(1'b0, 0); add_end(0);
      add_fwd(1'b0, 0); add_end(0); add_idle(0);
      // three stuffed groups then 0,1
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 6; i++) add_fwd(1'b1, g);
         add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, g + 1);
      end
      add_fwd(1'b0, 3); add_fwd(1'b1, 3); add_end(3); add_idle(3);

      #12;
      checkOutput("rst.valid", 0, {7'd0, out_valid_a}, 8'd0);
      checkOutput("rst.busy",  0, {7'd0, busy_a},      8'd0);
      checkOutput("rst.cnt",   0, stuff_cnt_a,         8'd0);
      checkOutput("rst.done",  0, {7'd0, pkt_done_a},  8'd0);
      reset = 1'b0;
      step;

      foreach (vec_q[i]) begin
         applyStimulus(vec_q[i].s, vec_q[i].b, 1'b0, 1'b0);
         step;
         checkOutput("a.valid", i, {7'd0, out_valid_a}, {7'd0, vec_q[i].v});
         checkOutput("a.bit",   i, {7'd0, out_bit_a},   {7'd0, vec_q[i].ob});
         checkOutput("a.err",   i, {7'd0, stuff_err_a}, {7'd0, vec_q[i].err});
         checkOutput("a.done",  i, {7'd0, pkt_done_a},  {7'd0, vec_q[i].done});
         checkOutput("a.busy",  i, {7'd0, busy_a},      {7'd0, vec_q[i].bsy});
         checkOutput("a.cnt",   i, stuff_cnt_a,         vec_q[i].cnt);
      end

      // asynchronous clear of a held stuff count
      #2 reset = 1'b1;
      #1 checkOutput("async.cnt", 0, stuff_cnt_a, 8'd0);
      #2 reset = 1'b0;
      step;

      // reset in the middle of a packet
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); step;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); step;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); step;
      checkOutput("mid.pre_valid", 0, {7'd0, out_valid_a}, 8'd1);
      checkOutput("mid.pre_bit",   0, {7'd0, out_bit_a},   8'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("mid.valid", 0, {7'd0, out_valid_a}, 8'd0);
      checkOutput("mid.bit",   0, {7'd0, out_bit_a},   8'd0);
      checkOutput("mid.busy",  0, {7'd0, busy_a},      8'd0);
      step;
      checkOutput("mid.done", 0, {7'd0, pkt_done_a},  8'd0);
      checkOutput("mid.err",  0, {7'd0, stuff_err_a}, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      step;
      checkOutput("rel.valid", 0, {7'd0, out_valid_a}, 8'd1);
      checkOutput("rel.bit",   0, {7'd0, out_bit_a},   8'd0);
      checkOutput("rel.busy",  0, {7'd0, busy_a},      8'd1);
      checkOutput("rel.done",  0, {7'd0, pkt_done_a},  8'd0);
      checkOutput("rel.cnt",   0, stuff_cnt_a,         8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); step;
      checkOutput("rel.bit",   1, {7'd0, out_bit_a},   8'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); step;
      checkOutput("rel.done",  1, {7'd0, pkt_done_a},  8'd1);
      step;

      // RUN_LEN=3, CNT_W=2: stuff counter saturates at 3
      for (int g = 0; g < 5; g++) begin
         for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); step;
            check_b("b.one", g * 4 + k, 1'b1, 1'b1, 1'b0, 1'b0, (g < 3) ? g : 3);
         end
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); step;
         check_b("b.stuff", g, 1'b0, 1'b0, 1'b0, 1'b0, (g + 1 < 3) ? g + 1 : 3);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); step;
      check_b("b.end", 0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      step;
      check_b("b.hold", 0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      // new packet clears the count, then ends right after a full run
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); step;
         check_b("b.run", k, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); step;
      check_b("b.endstuff", 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      checkOutput("b.busy", 0, {7'd0, busy_b}, 8'd0);
      step;
      check_b("b.idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
